// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: one single-entry buffer per requester
// (ALU, MEM), oldest-first grant with round-robin tie break, registered
// write port, and a pending-writeback scoreboard.
module rf_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_addr,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   alu_ready,
  input  logic                   mem_valid,
  input  logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   mem_ready,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic                   write_en,
  output logic [ADDR_W-1:0]      write_address,
  output logic [DATA_W-1:0]      data_in,
  output logic [2**ADDR_W-1:0]   pending
);

  localparam int NREG = 2**ADDR_W;

  // Buffers; *_old_q is the 1-bit age stamp: set when this entry was loaded
  // at a strictly earlier edge than the entry now held by the other buffer.
  logic              alu_full_q, alu_full_d, alu_old_q, alu_old_d;
  logic              mem_full_q, mem_full_d, mem_old_q, mem_old_d;
  logic [ADDR_W-1:0] alu_addr_q, mem_addr_q;
  logic [DATA_W-1:0] alu_data_q, mem_data_q;
  logic              rr_q, rr_d;
  logic              we_q;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wd_q;
  logic [NREG-1:0]   pend_q, pend_d;

  logic gnt_alu, gnt_mem, tie, alu_hs, mem_hs;

  // Grant selection: only full buffers compete; older wins, ties use rr.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    tie     = 1'b0;
    if (alu_full_q && mem_full_q) begin
      if (alu_old_q && !mem_old_q)      gnt_alu = 1'b1;
      else if (mem_old_q && !alu_old_q) gnt_mem = 1'b1;
      else begin
        tie = 1'b1;
        if (!rr_q) gnt_alu = 1'b1;
        else       gnt_mem = 1'b1;
      end
    end else begin
      gnt_alu = alu_full_q;
      gnt_mem = mem_full_q;
    end
  end

  assign alu_ready = rst_n && (!alu_full_q || gnt_alu);
  assign mem_ready = rst_n && (!mem_full_q || gnt_mem);
  assign alu_hs    = alu_valid && alu_ready;
  assign mem_hs    = mem_valid && mem_ready;

  // Next-state for buffers, age stamps, rr pointer and scoreboard.
  always_comb begin
    alu_full_d = alu_hs || (alu_full_q && !gnt_alu);
    mem_full_d = mem_hs || (mem_full_q && !gnt_mem);
    alu_old_d  = alu_old_q;
    mem_old_d  = mem_old_q;
    // A fresh load is never older; an entry that survives the edge while the
    // other side loads becomes the older one.
    if (alu_hs)                                    alu_old_d = 1'b0;
    else if (mem_hs && alu_full_q && !gnt_alu)     alu_old_d = 1'b1;
    if (mem_hs)                                    mem_old_d = 1'b0;
    else if (alu_hs && mem_full_q && !gnt_mem)     mem_old_d = 1'b1;
    rr_d   = tie ? !rr_q : rr_q;
    pend_d = pend_q;
    if (gnt_alu) pend_d[alu_addr_q] = 1'b0;
    if (gnt_mem) pend_d[mem_addr_q] = 1'b0;
    if (rsv_en)  pend_d[rsv_addr]   = 1'b1;  // set wins over clear
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_full_q <= 1'b0;
      mem_full_q <= 1'b0;
      alu_old_q  <= 1'b0;
      mem_old_q  <= 1'b0;
      alu_addr_q <= '0;
      alu_data_q <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      rr_q       <= 1'b0;
      we_q       <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      pend_q     <= '0;
    end else begin
      alu_full_q <= alu_full_d;
      mem_full_q <= mem_full_d;
      alu_old_q  <= alu_old_d;
      mem_old_q  <= mem_old_d;
      rr_q       <= rr_d;
      pend_q     <= pend_d;
      if (alu_hs) begin
        alu_addr_q <= alu_addr;
        alu_data_q <= alu_data;
      end
      if (mem_hs) begin
        mem_addr_q <= mem_addr;
        mem_data_q <= mem_data;
      end
      we_q <= gnt_alu || gnt_mem;
      if (gnt_alu) begin
        wa_q <= alu_addr_q;
        wd_q <= alu_data_q;
      end else if (gnt_mem) begin
        wa_q <= mem_addr_q;
        wd_q <= mem_data_q;
      end
    end
  end

  assign write_en      = we_q;
  assign write_address = wa_q;
  assign data_in       = wd_q;
  assign pending       = pend_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a timestamp-based reference model.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid, alu_ready, mem_ready;
  logic [3:0]  alu_addr, mem_addr, rsv_addr, write_address;
  logic [15:0] alu_data, mem_data, data_in, pending;
  logic        rsv_en, write_en;

  rf_wb_arbiter #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .write_en(write_en), .write_address(write_address), .data_in(data_in), .pending(pending)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each buffer remembers the edge number at which it was
  // loaded; the smaller number is older, equal numbers are a tie.
  bit          a_full, m_full, rr;
  int          a_t, m_t, edge_n;
  logic [3:0]  a_addr, m_addr, e_wa;
  logic [15:0] a_data, m_data, e_wd, e_pend;
  bit          e_we;

  task automatic model_reset();
    a_full = 0; m_full = 0; rr = 0; e_we = 0; e_wa = 0; e_wd = 0; e_pend = 0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check readies,
  // then advance the model across the coming edge.
  task automatic cyc(input bit rst, input bit av, input logic [3:0] aa, input logic [15:0] ad,
                     input bit mv, input logic [3:0] ma, input logic [15:0] md,
                     input bit re, input logic [3:0] ra);
    bit ga, gm, ra_ok, rm_ok, tie;
    @(negedge clk);
    chk("write_en", {31'b0, write_en}, {31'b0, e_we});
    chk("write_address", {28'b0, write_address}, {28'b0, e_wa});
    chk("data_in", {16'b0, data_in}, {16'b0, e_wd});
    chk("pending", {16'b0, pending}, {16'b0, e_pend});
    rst_n = rst; alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md; rsv_en = re; rsv_addr = ra;
    #1;
    ga = 0; gm = 0; tie = 0;
    if (a_full && m_full) begin
      if (a_t < m_t)      ga = 1;
      else if (m_t < a_t) gm = 1;
      else begin tie = 1; if (rr == 0) ga = 1; else gm = 1; end
    end else begin
      ga = a_full; gm = m_full;
    end
    ra_ok = rst && (!a_full || ga);
    rm_ok = rst && (!m_full || gm);
    chk("alu_ready", {31'b0, alu_ready}, {31'b0, ra_ok});
    chk("mem_ready", {31'b0, mem_ready}, {31'b0, rm_ok});
    if (!rst) begin
      model_reset();
    end else begin
      if (tie) rr = !rr;
      e_we = ga || gm;
      if (ga) begin e_wa = a_addr; e_wd = a_data; e_pend[a_addr] = 1'b0; a_full = 0; end
      if (gm) begin e_wa = m_addr; e_wd = m_data; e_pend[m_addr] = 1'b0; m_full = 0; end
      if (re) e_pend[ra] = 1'b1;
      if (av && ra_ok) begin a_full = 1; a_addr = aa; a_data = ad; a_t = edge_n; end
      if (mv && rm_ok) begin m_full = 1; m_addr = ma; m_data = md; m_t = edge_n; end
    end
    edge_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0; alu_valid = 0; mem_valid = 0; alu_addr = 0; mem_addr = 0;
    alu_data = 0; mem_data = 0; rsv_en = 0; rsv_addr = 0;
    edge_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single write: addr 1, data 0x0002.
    cyc(1, 1, 4'd1, 16'h0002, 0, 0, 0, 0, 0);
    idle(3);
    // Tie after reset: ALU first, then repeated tie goes MEM first.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 4'd3, 16'h00AA, 1, 4'd4, 16'h00BB, 0, 0);
    idle(3);
    cyc(1, 1, 4'd3, 16'h00AA, 1, 4'd4, 16'h00BB, 0, 0);
    idle(3);
    // Age: MEM reg 5 loaded one edge ahead of ALU reg 5, MEM kept busy.
    cyc(1, 1, 4'd6, 16'h0066, 1, 4'd5, 16'h0011, 0, 0);
    cyc(1, 1, 4'd5, 16'h0022, 1, 4'd9, 16'h0099, 0, 0);
    cyc(1, 0, 0, 0, 1, 4'd10, 16'h00A0, 0, 0);
    idle(4);
    // Scoreboard: reserve 7, ALU writes 7, then reserve 7 on the grant edge.
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 4'd7);
    idle(2);
    cyc(1, 1, 4'd7, 16'h0077, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    cyc(1, 1, 4'd7, 16'h0078, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 4'd7);
    idle(3);
    // Streaming: 16 back-to-back ALU writes, including PC (reg 15).
    for (int i = 0; i < 16; i++) cyc(1, 1, 4'(i), 16'(i), 0, 0, 0, 0, 0);
    idle(3);
    // Reset with both buffers full.
    cyc(1, 1, 4'd2, 16'h1234, 1, 4'd8, 16'h5678, 1, 4'd2);
    cyc(1, 1, 4'd11, 16'h4321, 1, 4'd12, 16'h8765, 1, 4'd11);
    cyc(0, 1, 4'd1, 16'h1111, 1, 4'd1, 16'h2222, 0, 0);
    idle(4);

    // Random traffic with occasional reset.
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 79) != 0),
          $urandom_range(0, 1) == 1, 4'($urandom), 16'($urandom),
          $urandom_range(0, 2) != 0, 4'($urandom), 16'($urandom),
          $urandom_range(0, 2) == 0, 4'($urandom));
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
